// File: rtl/elevator_pkg.sv
// elevator_pkg
//   Types and default constants shared by the elevator controller, display
//   and top-level stages.
//   - elev_state_t : controller FSM states (IDLE, MOVE_UP, MOVE_DOWN, DOOR)
//   - elev_dir_t   : SCAN sweep direction
//   - DEF_*        : default floor count and timing (12 MHz system clock)
//   - cnt_width()  : counter width for a cycle-count parameter (min 1 bit)
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } elev_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } elev_dir_t;

  localparam int DEF_FLOORS        = 4;
  localparam int DEF_TRAVEL_CYCLES = 12_000_000;  // 1 s per floor at 12 MHz
  localparam int DEF_DOOR_CYCLES   = 24_000_000;  // 2 s door dwell at 12 MHz

  // A count of n cycles runs 0..n-1, so $clog2(n) bits suffice; a 1-cycle
  // count still needs a 1-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_ctrl_key_edge_sync.sv
// key_edge_sync
//   Brings asynchronous, debounced key levels into the clk domain through a
//   2-flop synchroniser and turns each rising level into a single-cycle pulse.
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset, clears every flop
//     din   : WIDTH asynchronous key levels
//     rise  : WIDTH one-cycle pulses, high in the cycle after the synchronised
//             level first reads 1 (combinational from the flops)
module key_edge_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_q <= '0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      sync2_q <= sync2;
    end
  end

  // Only the 0->1 transition of the synchronised level counts, so a key held
  // for any length of time yields exactly one pulse.
  assign rise = sync2 & ~sync2_q;

endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl
//   Floor-request controller. Latches synchronised key presses as pending
//   requests and runs a SCAN policy: keep travelling in the current sweep
//   direction while requests remain that way, stop and open the door at
//   each requested floor, reverse when the sweep is exhausted.
//   Ports:
//     clk         : system clock
//     rst_n       : asynchronous active-low reset
//     key_req     : debounced call buttons, one per floor, asynchronous
//     cur_floor   : floor the car is at or last passed
//     dir_up      : car moving up
//     dir_down    : car moving down
//     door_open   : door open at cur_floor
//     req_pending : latched, unserviced requests
//   Build option: ELEV_DOOR_REOPEN_EN -- when defined, a press for cur_floor
//   while the door is open restarts the door timer; otherwise that press is
//   ignored.
//   Handshake: none; key_req is level-sampled, every output is a register.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOORS        = DEF_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FLOORS-1:0]         key_req,
  output logic [$clog2(FLOORS)-1:0] cur_floor,
  output logic                      dir_up,
  output logic                      dir_down,
  output logic                      door_open,
  output logic [FLOORS-1:0]         req_pending
);

  localparam int FW = $clog2(FLOORS);
  localparam int TW = cnt_width(TRAVEL_CYCLES);
  localparam int DW = cnt_width(DOOR_CYCLES);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  elev_state_t       state;
  elev_dir_t         last_dir;
  logic [TW-1:0]     travel_cnt;
  logic [DW-1:0]     door_cnt;

  logic [FLOORS-1:0] key_rise;
  logic [FLOORS-1:0] req_set;
  logic [FLOORS-1:0] req_merged;
  logic [FW-1:0]     floor_up;
  logic [FW-1:0]     floor_dn;
  logic              above;
  logic              below;
  logic              above_up;
  logic              below_dn;
  logic              travel_done;
  logic              door_done;
`ifdef ELEV_DOOR_REOPEN_EN
  logic              door_key;
`endif

  key_edge_sync #(
    .WIDTH (FLOORS)
  ) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (key_req),
    .rise  (key_rise)
  );

  function automatic logic any_above(input logic [FLOORS-1:0] req,
                                     input logic [FW-1:0]     fl);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (req[i] && (i > int'(fl))) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] req,
                                     input logic [FW-1:0]     fl);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (req[i] && (i < int'(fl))) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [FLOORS-1:0] floor_bit(input logic [FW-1:0] fl);
    logic [FLOORS-1:0] m;
    m     = '0;
    m[fl] = 1'b1;
    return m;
  endfunction

  always_comb begin
    // floor_up/floor_dn are only consumed while moving in that direction,
    // and the FSM never moves past either end, so no wrap is ever used.
    floor_up    = cur_floor + FW'(1);
    floor_dn    = cur_floor - FW'(1);
    above       = any_above(req_pending, cur_floor);
    below       = any_below(req_pending, cur_floor);
    above_up    = any_above(req_pending, floor_up);
    below_dn    = any_below(req_pending, floor_dn);
    travel_done = (travel_cnt == TRAVEL_LAST);
    door_done   = (door_cnt == DOOR_LAST);
    // A press for the floor whose door is already open is never latched.
    req_set     = key_rise;
    if (state == DOOR) req_set[cur_floor] = 1'b0;
    req_merged  = req_pending | req_set;
`ifdef ELEV_DOOR_REOPEN_EN
    door_key    = (state == DOOR) && key_rise[cur_floor];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_dir    <= DIR_UP;
      cur_floor   <= '0;
      travel_cnt  <= '0;
      door_cnt    <= '0;
      req_pending <= '0;
      dir_up      <= 1'b0;
      dir_down    <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      req_pending <= req_merged;
      // Indicator outputs follow the state register one cycle later, so each
      // is high for exactly as many cycles as the FSM sits in its state.
      dir_up      <= (state == MOVE_UP);
      dir_down    <= (state == MOVE_DOWN);
      door_open   <= (state == DOOR);

      case (state)
        IDLE: begin
          travel_cnt <= '0;
          door_cnt   <= '0;
          if (req_pending[cur_floor]) begin
            state       <= DOOR;
            req_pending <= req_merged & ~floor_bit(cur_floor);
          end else if (above) begin
            state    <= MOVE_UP;
            last_dir <= DIR_UP;
          end else if (below) begin
            state    <= MOVE_DOWN;
            last_dir <= DIR_DOWN;
          end
        end

        MOVE_UP: begin
          if (travel_done) begin
            travel_cnt <= '0;
            cur_floor  <= floor_up;
            // Clearing on DOOR entry overrides a same-cycle press of that floor.
            if (req_pending[floor_up]) begin
              state       <= DOOR;
              req_pending <= req_merged & ~floor_bit(floor_up);
            end else if (!above_up) begin
              state <= IDLE;
            end
          end else begin
            travel_cnt <= travel_cnt + TW'(1);
          end
        end

        MOVE_DOWN: begin
          if (travel_done) begin
            travel_cnt <= '0;
            cur_floor  <= floor_dn;
            if (req_pending[floor_dn]) begin
              state       <= DOOR;
              req_pending <= req_merged & ~floor_bit(floor_dn);
            end else if (!below_dn) begin
              state <= IDLE;
            end
          end else begin
            travel_cnt <= travel_cnt + TW'(1);
          end
        end

        DOOR: begin
`ifdef ELEV_DOOR_REOPEN_EN
          if (door_key) begin
            door_cnt <= '0;
          end else
`endif
          if (door_done) begin
            door_cnt <= '0;
            // SCAN: finish the current sweep before turning around.
            if ((last_dir == DIR_UP) && above) begin
              state <= MOVE_UP;
            end else if ((last_dir == DIR_DOWN) && below) begin
              state <= MOVE_DOWN;
            end else if (above) begin
              state    <= MOVE_UP;
              last_dir <= DIR_UP;
            end else if (below) begin
              state    <= MOVE_DOWN;
              last_dir <= DIR_DOWN;
            end else begin
              state <= IDLE;
            end
          end else begin
            door_cnt <= door_cnt + DW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl
//   Directed bench for elevator_ctrl with FLOORS=4, TRAVEL_CYCLES=8,
//   DOOR_CYCLES=5. Inputs change and outputs are sampled on the falling edge;
//   "cycle c" means the falling edge after the c-th rising edge following a
//   press. Expected floor transitions are queued in exp_q and popped by a
//   monitor whenever cur_floor changes. Honours ELEV_DOOR_REOPEN_EN.
module tb_elevator_ctrl;

  localparam int FLOORS = 4;
  localparam int TRAVEL = 8;
  localparam int DOOR_C = 5;
`ifdef ELEV_DOOR_REOPEN_EN
  localparam bit REOPEN = 1'b1;
`else
  localparam bit REOPEN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [FLOORS-1:0] key_req = '0;
  logic [1:0]        cur_floor;
  logic              dir_up;
  logic              dir_down;
  logic              door_open;
  logic [FLOORS-1:0] req_pending;

  always #5 clk = ~clk;

  elevator_ctrl #(
    .FLOORS        (FLOORS),
    .TRAVEL_CYCLES (TRAVEL),
    .DOOR_CYCLES   (DOOR_C)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_req     (key_req),
    .cur_floor   (cur_floor),
    .dir_up      (dir_up),
    .dir_down    (dir_down),
    .door_open   (door_open),
    .req_pending (req_pending)
  );

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  bit         mon_en = 1'b0;
  logic [1:0] exp_q[$];
  logic [1:0] prev_floor = 2'd0;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic press(input logic [FLOORS-1:0] keys);
    key_req = keys;
    cyc     = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic check_outs(input string tag, input logic [1:0] e_floor,
                            input logic e_up, input logic e_dn,
                            input logic e_door, input logic [3:0] e_pend);
    check_eq({tag, "_floor"}, 32'(cur_floor), 32'(e_floor));
    check_eq({tag, "_up"},    32'(dir_up),    32'(e_up));
    check_eq({tag, "_down"},  32'(dir_down),  32'(e_dn));
    check_eq({tag, "_door"},  32'(door_open), 32'(e_door));
    check_eq({tag, "_pend"},  32'(req_pending), 32'(e_pend));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("outs_exclusive", 32'($onehot0({dir_up, dir_down, door_open})), 32'd1);
      if (cur_floor != prev_floor) begin
        if (exp_q.size() == 0) check_eq("floor_unexpected", 32'(cur_floor), 32'(prev_floor));
        else                   check_eq("floor_seq", 32'(cur_floor), 32'(exp_q.pop_front()));
        prev_floor = cur_floor;
      end
    end
  end

  // ---------------- stimulus ----------------
  int first_pend, pend_n, door_n, first_door;

  initial begin
    rst_n   = 1'b0;
    key_req = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    mon_en = 1'b1;

    // S1: hold floor-0 key for 40 cycles -> one request, one door cycle
    first_pend = -1; first_door = -1; pend_n = 0; door_n = 0;
    press(4'b0001);
    repeat (40) begin
      step_to(cyc + 1);
      if (req_pending != '0) begin
        pend_n++;
        if (first_pend < 0) first_pend = cyc;
      end
      if (door_open) begin
        door_n++;
        if (first_door < 0) first_door = cyc;
      end
    end
    check_eq("s1_first_pend", 32'(first_pend), 32'd3);
    check_eq("s1_pend_cycles", 32'(pend_n), 32'd1);
    check_eq("s1_first_door", 32'(first_door), 32'd5);
    check_eq("s1_door_cycles", 32'(door_n), 32'd5);
    check_outs("s1_end", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    key_req = '0;
    idle(4);

    // S2: floor 0 -> floor 3
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    press(4'b1000);
    step_to(3);  check_outs("s2_c3", 2'd0, 1'b0, 1'b0, 1'b0, 4'b1000);
    step_to(4);  check_eq("s2_c4_up", 32'(dir_up), 32'd0);
    step_to(5);  check_eq("s2_c5_up", 32'(dir_up), 32'd1);
    key_req = '0;
    step_to(11); check_eq("s2_c11_floor", 32'(cur_floor), 32'd0);
    step_to(12); check_eq("s2_c12_floor", 32'(cur_floor), 32'd1);
    step_to(20); check_eq("s2_c20_floor", 32'(cur_floor), 32'd2);
    step_to(28); check_outs("s2_c28", 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000);
    step_to(29); check_outs("s2_c29", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000);
    step_to(33); check_eq("s2_c33_door", 32'(door_open), 32'd1);
    step_to(34); check_eq("s2_c34_door", 32'(door_open), 32'd0);
    step_to(36); check_outs("s2_idle", 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000);

    // back to floor 0 via reset
    exp_q.push_back(2'd0);
    pulse_reset();
    check_outs("s2_reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // S3: heading for 3, floor 0 pressed at floor 1 -> serve 3, then reverse
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    exp_q.push_back(2'd2); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    press(4'b1000);
    step_to(5);  key_req = '0;
    step_to(13); check_outs("s3_c13", 2'd1, 1'b1, 1'b0, 1'b0, 4'b1000);
    key_req = 4'b0001;
    step_to(16); check_eq("s3_c16_pend", 32'(req_pending), 32'b1001);
    step_to(18); key_req = '0;
    step_to(28); check_outs("s3_c28", 2'd3, 1'b1, 1'b0, 1'b0, 4'b0001);
    step_to(29); check_eq("s3_c29_door", 32'(door_open), 32'd1);
    step_to(33); check_outs("s3_c33", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0001);
    step_to(34); check_outs("s3_c34", 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001);
    step_to(41); check_eq("s3_c41_floor", 32'(cur_floor), 32'd2);
    step_to(57); check_outs("s3_c57", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
    step_to(58); check_outs("s3_c58", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step_to(62); check_eq("s3_c62_door", 32'(door_open), 32'd1);
    step_to(63); check_outs("s3_c63", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // S4: floor-2 press lands in the same cycle the car enters DOOR at 2
    exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    press(4'b0100);
    step_to(5);  key_req = '0;
    step_to(17); key_req = 4'b0100;
    step_to(19); check_outs("s4_c19", 2'd1, 1'b1, 1'b0, 1'b0, 4'b0100);
    step_to(20); check_outs("s4_c20", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
    door_n = 0; pend_n = 0;
    while (cyc < 40) begin
      step_to(cyc + 1);
      if (door_open) door_n++;
      if (req_pending != '0) pend_n++;
    end
    check_eq("s4_door_cycles", 32'(door_n), 32'd5);
    check_eq("s4_pend_cycles", 32'(pend_n), 32'd0);
    check_outs("s4_end", 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    key_req = '0;
    idle(4);

    // S6: press cur_floor while the door is open
    press(4'b0100);
    step_to(2);  key_req = '0;
    step_to(3);  check_eq("s6_c3_pend", 32'(req_pending), 32'b0100);
    step_to(4);  check_outs("s6_c4", 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    key_req = 4'b0100;
    step_to(5);  check_eq("s6_c5_door", 32'(door_open), 32'd1);
    step_to(7);  check_eq("s6_c7_pend", 32'(req_pending), 32'd0);
    step_to(8);  check_eq("s6_c8_pend", 32'(req_pending), 32'd0);
    key_req = '0;
    step_to(9);  check_eq("s6_c9_door", 32'(door_open), 32'd1);
    step_to(10); check_eq("s6_c10_door", 32'(door_open), 32'(REOPEN));
    step_to(12); check_eq("s6_c12_door", 32'(door_open), 32'(REOPEN));
    step_to(13); check_eq("s6_c13_door", 32'(door_open), 32'd0);
    step_to(16); check_outs("s6_end", 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);

    // S5: asynchronous reset mid-move at floor 2 going up
    press(4'b1001);
    step_to(5);  check_outs("s5_c5", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
    step_to(6);
    key_req = '0;
    exp_q.push_back(2'd0);
    rst_n = 1'b0;
    #1;
    check_outs("s5_async", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    idle(2);
    rst_n = 1'b1;
    idle(20);
    check_outs("s5_after", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    mon_en = 1'b0;
    check_eq("floor_queue_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Floor-request controller for the elevator design. Sits directly downstream of the per-button debounce stages. It takes their debounced key pulses, synchronises and edge-detects them into the system clock, and latches them as pending floor requests. A SCAN-policy state machine then moves the car floor by floor, opens the door at requested floors, and drives the current-floor and direction outputs consumed by the display stage.

## Interface
- `FLOORS`, 4: number of floors, 2..8; floor 0 is lowest.
- `TRAVEL_CYCLES`, 12000000: clk cycles to travel one floor (1 s at 12 MHz).
- `DOOR_CYCLES`, 24000000: clk cycles the door stays open.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_req` in FLOORS: debounced call buttons, one bit per floor. Each is a pulse from a debounce stage, high for many clk cycles and not clk-synchronous.
- `cur_floor` out $clog2(FLOORS): floor the car is at or last passed.
- `dir_up` out 1: car moving up.
- `dir_down` out 1: car moving down.
- `door_open` out 1: door open at `cur_floor`.
- `req_pending` out FLOORS: latched, unserviced requests.

## Operation
- Each `key_req` bit passes through a 2-flop synchroniser and then a rising-edge detector. One press produces exactly one request event, however long the bit stays high.
- A request event for floor f sets `req_pending[f]`. The only exceptions are the cases handled in DOOR and Configuration.
- State machine states: IDLE, MOVE_UP, MOVE_DOWN, DOOR. A `last_dir` register (up/down) holds the SCAN direction; its reset value is up.
- "above" = any pending request for a floor greater than `cur_floor`. "below" = any pending request for a floor less than `cur_floor`.
- IDLE:
  - If `req_pending[cur_floor]` is set, go to DOOR.
  - Else if above, go to MOVE_UP.
  - Else if below, go to MOVE_DOWN.
  - Ties go up.
- MOVE_UP / MOVE_DOWN:
  - The travel counter runs from 0 to TRAVEL_CYCLES-1.
  - On expiry, `cur_floor` steps ±1 and the counter clears.
  - If the new floor is pending, go to DOOR; otherwise continue.
  - On entry, set `last_dir` to match the move direction.
- DOOR:
  - On entry, clear `req_pending[cur_floor]`.
  - The door counter runs DOOR_CYCLES.
  - On expiry, continue in `last_dir` if requests exist in that direction; else reverse if any exist the other way; else go to IDLE.
- Arithmetic: `cur_floor` never goes below 0 or above FLOORS-1. MOVE_UP is never entered at the top floor, and MOVE_DOWN never at floor 0. Counters are sized $clog2 of their parameter.
- If a request event and the DOOR-entry clear hit the same floor in the same cycle, the clear wins.
- An asynchronous reset mid-operation forces IDLE, floor 0, and all requests, counters and synchroniser flops to 0.

## Timing
- Reset values: `cur_floor`=0, `dir_up`=0, `dir_down`=0, `door_open`=0, `req_pending`=0. All outputs are registered.
- Input latency: `req_pending[f]` rises 3 clk cycles after `key_req[f]` rises (2 synchroniser cycles + 1 edge/latch cycle).
- IDLE leaves on the cycle after a request becomes pending. `dir_up`, `dir_down` and `door_open` reflect the new state 1 cycle after the transition.
- Per floor, `cur_floor` updates exactly TRAVEL_CYCLES cycles after the move starts.
- `door_open` stays high for exactly DOOR_CYCLES cycles.
- `dir_up`, `dir_down` and `door_open` are mutually exclusive.

## Configuration
- `ELEV_DOOR_REOPEN_EN` defined: a request event for `cur_floor` while in DOOR restarts the door counter. `door_open` is extended and `req_pending` is not set.
- Not defined: that event is dropped. The door closes on the original schedule and `req_pending` stays clear.

## Structure
- `elevator_pkg`: state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR), direction enum, and the default FLOORS/timing constants shared with the display and top-level stages.
- Sub-module `key_edge_sync`: a parameterised-width 2-flop synchroniser plus rising-edge detector, with `clk`/`rst_n`. It is instantiated once, FLOORS bits wide.

## Test plan
All scenarios use FLOORS=4, TRAVEL_CYCLES=8, DOOR_CYCLES=5.
- Reset, then hold `key_req`=0001 for 40 cycles → `req_pending` pulses 0001 at cycle 3; DOOR for 5 cycles; `cur_floor` stays 0; exactly one door cycle.
- Press floor 3 from IDLE at floor 0 → `dir_up`=1; `cur_floor` 1, 2, 3 at 8-cycle intervals; `door_open`=1 for 5 cycles; `req_pending`=0000; then IDLE.
- At floor 1 moving up with floor 3 pending, press floor 0 → car services floor 3 first, then reverses: `dir_down`=1 and the door opens at floor 0.
- Request floor 2 arriving in the same cycle the car enters DOOR at floor 2 → `req_pending[2]`=0 afterwards and no second door cycle.
- Assert `rst_n`=0 mid-move at floor 2 going up → all outputs 0 immediately; IDLE after release; pending requests lost.
- Press `cur_floor` during DOOR → with `ELEV_DOOR_REOPEN_EN`, `door_open` lasts 5 cycles past the press; without it, door closes at the original cycle and `req_pending` stays 0.
